// File: rtl/dbx_zrle_encoder.sv
// Zero-run-length encoder between the per-bit-plane DBX symbol encoder and the bit packer.
// Collapses runs of zero DBX symbols into ZRLE codes; non-zero symbols pass through in order.
module dbx_zrle_encoder #(
    parameter int SYMB_W = 8,
    parameter int LEN_W  = 4,
    parameter int ZRUN_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_zero_i,
    input  logic [SYMB_W-1:0] in_symb_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SYMB_W-1:0] out_symb_o,
    output logic [LEN_W-1:0]  out_len_o,
    output logic              out_last_o,
    output logic              idle_o
);

    localparam int MAX_ZRUN = (1 << ZRUN_W) + 1;
    localparam logic [ZRUN_W:0] CNT_MAX  = (ZRUN_W+1)'(MAX_ZRUN);
    localparam logic [ZRUN_W:0] CNT_ONE  = (ZRUN_W+1)'(1);
    localparam logic [ZRUN_W:0] CNT_ZERO = '0;

    generate
        if (SYMB_W < 3 + ZRUN_W) begin : g_bad_symb_w
            $error("dbx_zrle_encoder: SYMB_W must be >= 3+ZRUN_W");
        end
        if ((1 << LEN_W) <= 3 + ZRUN_W) begin : g_bad_len_w
            $error("dbx_zrle_encoder: LEN_W too narrow to encode a run-code length");
        end
    endgenerate

    typedef struct packed {
        logic [SYMB_W-1:0] symb;
        logic [LEN_W-1:0]  len;
        logic              last;
    } sym_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // k=1 -> "01"; k>=2 -> "001" + (k-2) on ZRUN_W bits; always MSB-aligned, zero-filled.
    function automatic sym_t run_code(input logic [ZRUN_W:0] k, input logic last);
        sym_t c;
        c      = '0;
        c.last = last;
        if (k == CNT_ONE) begin
            c.symb[SYMB_W-1 -: 2] = 2'b01;
            c.len                 = LEN_W'(2);
        end else begin
            c.symb[SYMB_W-1 -: 3]      = 3'b001;
            c.symb[SYMB_W-4 -: ZRUN_W] = ZRUN_W'(k - CNT_ONE - CNT_ONE);
            c.len                      = LEN_W'(3 + ZRUN_W);
        end
        return c;
    endfunction

    state_t          state, state_n;
    logic [ZRUN_W:0] cnt, cnt_n;
    logic [ZRUN_W:0] cnt_inc;
    sym_t            out_q, ld_d;
    logic            out_vld_q;
    logic            load;
    logic            out_free;
    logic            run_break;
    logic            accept;

    assign out_free  = !out_vld_q || out_ready_i;
    assign cnt_inc   = cnt + CNT_ONE;
    // A non-zero symbol arriving mid-run is held off until the run code has been issued.
    assign run_break = (state == S_RUN) && in_valid_i && !in_zero_i;
    assign in_ready_o = out_free && !run_break;
    assign accept    = in_valid_i && in_ready_o;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        ld_d    = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!in_zero_i) begin
                        load = 1'b1;
                        ld_d = '{symb: in_symb_i, len: in_len_i, last: in_last_i};
                    end else if (!in_last_i) begin
                        cnt_n   = CNT_ONE;
                        state_n = S_RUN;
                    end else begin
                        load = 1'b1;
                        ld_d = run_code(CNT_ONE, 1'b1);
                    end
                end
            end
            S_RUN: begin
                if (run_break) begin
                    if (out_free) begin
                        load    = 1'b1;
                        ld_d    = run_code(cnt, 1'b0);
                        cnt_n   = CNT_ZERO;
                        state_n = S_IDLE;
                    end
                end else if (accept) begin
                    if (cnt_inc == CNT_MAX || in_last_i) begin
                        load    = 1'b1;
                        ld_d    = run_code(cnt_inc, in_last_i);
                        cnt_n   = CNT_ZERO;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= CNT_ZERO;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                out_vld_q <= 1'b1;
                out_q     <= ld_d;
            end else if (out_ready_i) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_vld_q;
    assign out_symb_o  = out_q.symb;
    assign out_len_o   = out_q.len;
    assign out_last_o  = out_q.last;
    assign idle_o      = (state == S_IDLE) && !out_vld_q;

endmodule

// File: tb/tb_dbx_zrle_encoder.sv
// Bench for dbx_zrle_encoder: vector table, hand-written corner sequences and a
// scoreboard fed by a stream-level reference model of the zero-run collapsing.
module tb_dbx_zrle_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_zero = 1'b0;
    logic [7:0] in_symb = 8'h00;
    logic [3:0] in_len = 4'h0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_symb;
    logic [3:0] out_len;
    logic       out_last;
    logic       idle;

    always #5 clk = ~clk;

    dbx_zrle_encoder #(.SYMB_W(8), .LEN_W(4), .ZRUN_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_zero_i(in_zero),
        .in_symb_i(in_symb), .in_len_i(in_len), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_symb_o(out_symb),
        .out_len_o(out_len), .out_last_o(out_last), .idle_o(idle)
    );

    typedef struct {
        logic [7:0] symb;
        logic [3:0] len;
        logic       last;
    } sym_t;

    typedef struct {
        bit         zero;
        logic [7:0] symb;
        logic [3:0] len;
        bit         last;
        sym_t       exp;
    } vec_t;

    sym_t exp_q[$];
    sym_t out_log[$];
    int   m_cnt;
    int   n_checks;
    int   n_fail;
    bit   rand_rdy;

    // Run code for k zeros with SYMB_W=8, ZRUN_W=4: "01000000"/2 or "001kkkk0"/7.
    function automatic sym_t rcode(input int k, input bit last);
        sym_t c;
        if (k == 1) begin
            c.symb = 8'h40;
            c.len  = 4'd2;
        end else begin
            c.symb = 8'h20 | 8'((k - 2) << 1);
            c.len  = 4'd7;
        end
        c.last = last;
        return c;
    endfunction

    task automatic model_accept(input bit z, input logic [7:0] s, input logic [3:0] l, input bit last);
        sym_t d;
        if (z) begin
            m_cnt++;
            if (m_cnt == 17 || last) begin
                exp_q.push_back(rcode(m_cnt, last));
                m_cnt = 0;
            end
        end else begin
            if (m_cnt > 0) exp_q.push_back(rcode(m_cnt, 1'b0));
            m_cnt  = 0;
            d.symb = s;
            d.len  = l;
            d.last = last;
            exp_q.push_back(d);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_sym(input string name, input sym_t act, input sym_t exp);
        n_checks++;
        if (act.symb !== exp.symb || act.len !== exp.len || act.last !== exp.last) begin
            n_fail++;
            $display("FAIL %s: got %h/%0d/%0d, expected %h/%0d/%0d", name,
                     act.symb, act.len, act.last, exp.symb, exp.len, exp.last);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input sym_t exp);
        sym_t none;
        if (idx >= out_log.size()) begin
            none.symb = 8'h00;
            none.len  = 4'h0;
            none.last = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL %s: output #%0d missing, expected %h/%0d/%0d", name, idx,
                     exp.symb, exp.len, exp.last);
        end else begin
            chk_sym(name, out_log[idx], exp);
        end
    endtask

    function automatic sym_t cur_out();
        sym_t c;
        c.symb = out_symb;
        c.len  = out_len;
        c.last = out_last;
        return c;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input bit z, input logic [7:0] s, input logic [3:0] l, input bit last,
                        output int stalls);
        bit done = 0;
        in_valid = 1'b1;
        in_zero  = z;
        in_symb  = z ? 8'($urandom) : s;
        in_len   = z ? 4'($urandom) : l;
        in_last  = last;
        stalls   = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            #1;
            if (in_ready) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never asserted, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && !idle; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, {31'd0, idle}, 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int   st;
        int   base;
        sym_t held;
        bit   z;
        bit   lst;
        logic [3:0] l;
        logic [7:0] s;
        logic [7:0] m;

        vecs[0] = '{zero: 0, symb: 8'hA5, len: 4'd8, last: 0, exp: '{symb: 8'hA5, len: 4'd8, last: 1'b0}};
        vecs[1] = '{zero: 1, symb: 8'h00, len: 4'd0, last: 1, exp: '{symb: 8'h40, len: 4'd2, last: 1'b1}};
        vecs[2] = '{zero: 0, symb: 8'hC3, len: 4'd8, last: 1, exp: '{symb: 8'hC3, len: 4'd8, last: 1'b1}};
        vecs[3] = '{zero: 0, symb: 8'h80, len: 4'd1, last: 0, exp: '{symb: 8'h80, len: 4'd1, last: 1'b0}};
        vecs[4] = '{zero: 1, symb: 8'h00, len: 4'd0, last: 1, exp: '{symb: 8'h40, len: 4'd2, last: 1'b1}};

        m_cnt = 0; n_checks = 0; n_fail = 0; rand_rdy = 0;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    m_cnt = 0;
                    exp_q.delete();
                end else begin
                    if (in_valid && in_ready) model_accept(in_zero, in_symb, in_len, in_last);
                    if (out_valid && out_ready) begin
                        out_log.push_back(cur_out());
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL scoreboard: unexpected output %h/%0d/%0d, expected none",
                                     out_symb, out_len, out_last);
                        end else begin
                            chk_sym("scoreboard", cur_out(), exp_q.pop_front());
                        end
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
            end
        join_none

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_symb", {24'd0, out_symb}, 32'd0);
        chk("rst_len", {28'd0, out_len}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single-symbol vectors from IDLE: output exactly one cycle after acceptance
        foreach (vecs[i]) begin
            send(vecs[i].zero, vecs[i].symb, vecs[i].len, vecs[i].last, st);
            chk($sformatf("vec%0d_stall", i), st, 0);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk_sym($sformatf("vec%0d_out", i), cur_out(), vecs[i].exp);
        end
        @(posedge clk);
        #1;
        chk("vec_no_extra", {31'd0, out_valid}, 32'd0);
        wait_idle("vec_idle");

        // three zeros then a non-zero last: one stall cycle, run code then symbol
        base = out_log.size();
        repeat (3) send(1, 8'h00, 4'd0, 0, st);
        send(0, 8'hC0, 4'd5, 1, st);
        chk("t2_stall", st, 1);
        wait_idle("t2_idle");
        chk_log("t2_code", base, '{symb: 8'h22, len: 4'd7, last: 1'b0});
        chk_log("t2_symb", base + 1, '{symb: 8'hC0, len: 4'd5, last: 1'b1});

        // single zero then non-zero
        base = out_log.size();
        send(1, 8'h00, 4'd0, 0, st);
        send(0, 8'hE0, 4'd5, 0, st);
        chk("t3_stall", st, 1);
        wait_idle("t3_idle");
        chk_log("t3_code", base, '{symb: 8'h40, len: 4'd2, last: 1'b0});
        chk_log("t3_symb", base + 1, '{symb: 8'hE0, len: 4'd5, last: 1'b0});

        // 18 zeros, last on the 18th: saturated run then a fresh k=1 run
        base = out_log.size();
        for (int i = 0; i < 18; i++) begin
            send(1, 8'h00, 4'd0, (i == 17), st);
            if (i == 16) begin
                chk("t4_sat_valid", {31'd0, out_valid}, 32'd1);
                chk_sym("t4_sat_out", cur_out(), '{symb: 8'h3E, len: 4'd7, last: 1'b0});
            end
        end
        wait_idle("t4_idle");
        chk_log("t4_code17", base, '{symb: 8'h3E, len: 4'd7, last: 1'b0});
        chk_log("t4_code1", base + 1, '{symb: 8'h40, len: 4'd2, last: 1'b1});
        chk("t4_count", out_log.size() - base, 2);

        // output backpressure with a pending output and valid input
        out_ready = 1'b0;
        send(0, 8'h11, 4'd8, 0, st);
        held = cur_out();
        in_valid = 1'b1; in_zero = 1'b0; in_symb = 8'h33; in_len = 4'd8; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t5_valid", {31'd0, out_valid}, 32'd1);
            chk_sym("t5_hold", cur_out(), held);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(0, 8'h33, 4'd8, 0, st);
        wait_idle("t5_idle");

        // random stream against the reference model, random downstream stalls
        rand_rdy = 1;
        for (int n = 0; n < 10000; n++) begin
            z   = ($urandom_range(0, 9) < 3);
            l   = 4'($urandom_range(1, 8));
            m   = 8'hFF;
            m   = m << (8 - int'(l));
            s   = 8'($urandom) & m;
            lst = ($urandom_range(0, 19) == 0);
            send(z, s, l, lst, st);
        end
        // flush any open run so the model and DUT both drain
        send(1, 8'h00, 4'd0, 1, st);
        rand_rdy = 0;
        out_ready = 1'b1;
        wait_idle("t5_rand_idle");
        chk("t5_rand_drained", exp_q.size(), 0);

        // reset in the middle of a 4-zero run discards it
        repeat (4) send(1, 8'h00, 4'd0, 0, st);
        chk("t6_busy", {31'd0, idle}, 32'd0);
        base = out_log.size();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(0, 8'h99, 4'd8, 1, st);
        chk("t6_stall", st, 0);
        wait_idle("t6_idle");
        chk_log("t6_symb", base, '{symb: 8'h99, len: 4'd8, last: 1'b1});
        chk("t6_count", out_log.size() - base, 1);
        chk("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbx_zrle_encoder.md
Name: dbx_zrle_encoder

Overview:
- Sits directly downstream of the per-bit-plane DBX symbol encoder.
- Consumes one code symbol per bit-plane: zero flag, MSB-aligned symbol, length, last-of-block.
- Replaces runs of zero DBX symbols with zero-run-length (ZRLE) codes and passes non-zero symbols through unchanged.
- Drives a registered valid/ready stream into the bit packer.

Parameters:
- SYMB_W, 8, width of the MSB-aligned symbol field (input and output).
- LEN_W, 4, width of the symbol length field in bits.
- ZRUN_W, 4, width of the run-length field in ZRLE codes. MAX_ZRUN = 2^ZRUN_W + 1 (default 17). Elaboration error unless SYMB_W >= 3+ZRUN_W.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input symbol valid.
- in_ready_o  out  1  input symbol accepted when in_valid_i && in_ready_o.
- in_zero_i  in  1  symbol is a zero DBX; in_symb_i and in_len_i are don't-care (may be X).
- in_symb_i  in  SYMB_W  MSB-aligned code bits.
- in_len_i  in  LEN_W  number of valid MSBs in in_symb_i.
- in_last_i  in  1  last bit-plane symbol of the block.
- out_valid_o  out  1  output symbol valid (registered).
- out_ready_i  in  1  downstream accepts the output symbol.
- out_symb_o  out  SYMB_W  MSB-aligned output code; unused LSBs are 0.
- out_len_o  out  LEN_W  valid bits in out_symb_o.
- out_last_o  out  1  final symbol of the block.
- idle_o  out  1  state IDLE and !out_valid_o.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - out_valid_o=0; out_symb_o=0; out_len_o=0; out_last_o=0.
  - State=IDLE; run counter cnt=0; idle_o=1.
  - Reset mid-run discards the pending run; no output is emitted for it.
- Output register:
  - out_free = !out_valid_o || out_ready_i.
  - A load happens only when out_free. A load sets out_valid_o=1 with new data.
  - If out_valid_o && out_ready_i and nothing is loaded, out_valid_o=0 next cycle.
  - While out_valid_o && !out_ready_i, all out_* fields hold stable.
- Run code encoding for run length k:
  - k=1: symb = 01 followed by zeros; len=2.
  - 2 <= k <= MAX_ZRUN: symb = 001, then (k-2) on ZRUN_W bits MSB-first, then zeros; len = 3+ZRUN_W.
- State IDLE (no pending run), with in_ready_o = out_free:
  - Accept non-zero: load in_symb_i, in_len_i, in_last_i. Latency 1 cycle. State stays IDLE.
  - Accept zero, !in_last_i: cnt=1; go to RUN; no output.
  - Accept zero, in_last_i: load the k=1 code with out_last_o=1; stay in IDLE.
- State RUN (1 <= cnt < MAX_ZRUN):
  - in_valid_i && !in_zero_i: in_ready_o=0.
    - If out_free: load run code k=cnt, last=0; cnt=0; go to IDLE.
    - The non-zero symbol is accepted on a later cycle from IDLE.
    - This is the only case where the encoder stalls the input while the output slot is free.
  - Otherwise in_ready_o = out_free.
  - Accept zero with cnt+1 < MAX_ZRUN and !in_last_i: cnt=cnt+1; no output.
  - Accept zero with cnt+1 = MAX_ZRUN or in_last_i: load run code k=cnt+1, last=in_last_i; cnt=0; go to IDLE.
  - A saturated run followed by more zeros starts a new run.
  - !in_valid_i: hold state and cnt; a run never times out.
- Boundary rules:
  - A block never ends in RUN: a last symbol always flushes the run.
  - A non-zero last symbol that follows a run yields two outputs: the run code (last=0), then the symbol (last=1).
  - cnt is ZRUN_W+1 bits wide and never exceeds MAX_ZRUN.
  - Output valid/data never depend combinationally on inputs.
  - in_ready_o depends combinationally on out_ready_i, state, in_valid_i and in_zero_i only.
- Ordering: output symbol order equals input order, with each zero run collapsed in place.

Test Plan:
1. IDLE, out_ready_i=1: non-zero symb=0xA5, len=8, last=0. Required: out 0xA5/8 valid exactly 1 cycle later; in_ready_o stays 1.
2. Three zeros, then non-zero 0xC0/5 (last=1). Required: in_ready_o=0 for one cycle when 0xC0 is presented. Out sequence is 0x22 (001 0001 0) len 7 last 0, then 0xC0 len 5 last 1.
3. One zero, then non-zero 0xE0/5. Required: out 0x40 len 2, then 0xE0 len 5. Also a lone zero with last=1: required out 0x40 len 2 last 1, no further output, idle_o=1.
4. 18 consecutive zeros, last on the 18th. Required: out 0x3E (001 1111 0) len 7 last 0 after the 17th zero, then 0x40 len 2 last 1.
5. out_ready_i=0 for 5 cycles with an output pending and input valid. Required: out fields stable, in_ready_o=0. On release, one transfer per cycle with no loss or duplication, checked against a reference model over 10k random symbols (30% zero).
6. rst_i=1 while cnt=4 in RUN. Required: next cycle out_valid_o=0, idle_o=1, and no run code is ever emitted for those 4 zeros.
